// File: rtl/checker_ctrl_pkg.sv
// rtl/checker_ctrl_pkg.sv - shared state encodings, status bit indices and helpers for checker_ctrl
package checker_ctrl_pkg;

  typedef enum logic [2:0] {
    CHECKER_CTRL_STATE_IDLE  = 3'd0,
    CHECKER_CTRL_STATE_START = 3'd1,
    CHECKER_CTRL_STATE_RUN   = 3'd2,
    CHECKER_CTRL_STATE_IRQ   = 3'd3,
    CHECKER_CTRL_STATE_DONE  = 3'd4
  } ctrl_state_t;

  localparam int CHECKER_CTRL_STATUS_ERROR   = 0;
  localparam int CHECKER_CTRL_STATUS_ABORTED = 1;
  localparam int CHECKER_CTRL_STATUS_TIMEOUT = 2;

  localparam logic [15:0] IRQ_COUNT_MAX = 16'hffff;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == IRQ_COUNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/checker_ctrl_wdt.sv
// rtl/checker_ctrl_wdt.sv - clear/enable watchdog counter with expire flag
module checker_ctrl_wdt #(
  parameter int WDT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [WDT_W-1:0] i_limit,
  output logic             o_expire
);

  localparam logic [WDT_W-1:0] ONE = 1;

  logic [WDT_W-1:0] r_count;

  // count enabled cycles since the last clear; a zero limit never expires
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + ONE;
    end
  end

  assign o_expire = (i_limit != '0) && (r_count == i_limit - ONE);

endmodule

// File: rtl/checker_ctrl.sv
// rtl/checker_ctrl.sv - sequencer between the host CSR layer and the shared checker mode bus
module checker_ctrl
  import checker_ctrl_pkg::*;
#(
  parameter int MODE_W = 2,
  parameter int WDT_W  = 32
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic                         cmd_start,
  input  logic [MODE_W-1:0]            cmd_mode,
  input  logic [63:0]                  cmd_addr,
  input  logic [WDT_W-1:0]             cmd_timeout,
  input  logic                         cmd_abort,
  input  logic                         cmd_ack,
  output logic [MODE_W-1:0]            mode_mode,
  output logic                         mode_start,
  output logic [63:0]                  mode_addr,
  output logic                         mode_ack,
  input  logic [(1<<MODE_W)-1:0]       eng_end,
  input  logic [64*(1<<MODE_W)-1:0]    eng_data,
  input  logic [(1<<MODE_W)-1:0]       eng_irq,
  input  logic [(1<<MODE_W)-1:0]       eng_error,
  output logic                         busy,
  output logic                         done,
  output logic [2:0]                   status,
  output logic [63:0]                  res_data,
  output logic                         irq,
  output logic [15:0]                  irq_count
);

  ctrl_state_t      r_state;
  logic             r_start_q;
  logic [WDT_W-1:0] r_timeout;

  logic             w_sel_end;
  logic             w_sel_irq;
  logic             w_sel_error;
  logic [63:0]      w_sel_data;
  logic             w_wdt_expire;
  logic             w_in_run;
  logic             w_run_exit;

  assign w_sel_end   = eng_end[mode_mode];
  assign w_sel_irq   = eng_irq[mode_mode];
  assign w_sel_error = eng_error[mode_mode];
  assign w_sel_data  = eng_data[{mode_mode, 6'd0} +: 64];

  assign w_in_run   = (r_state == CHECKER_CTRL_STATE_RUN);
  assign w_run_exit = w_sel_end | w_sel_error | cmd_abort | w_wdt_expire;

  // drop start in the very cycle the end is seen so an idle engine cannot relaunch
  assign mode_start = r_start_q & ~(w_in_run & w_sel_end);

  checker_ctrl_wdt #(.WDT_W(WDT_W)) u_wdt (
    .i_clk    (sys_clk),
    .i_rst_n  (sys_rst),
    .i_clear  (r_state == CHECKER_CTRL_STATE_START),
    .i_enable (w_in_run),
    .i_limit  (r_timeout),
    .o_expire (w_wdt_expire)
  );

  // run sequencer with latched command parameters and registered host/engine outputs
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state   <= CHECKER_CTRL_STATE_IDLE;
      r_start_q <= 1'b0;
      r_timeout <= '0;
      mode_mode <= '0;
      mode_addr <= '0;
      mode_ack  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      status    <= '0;
      res_data  <= '0;
      irq       <= 1'b0;
      irq_count <= '0;
    end else begin
      done     <= 1'b0;
      mode_ack <= 1'b0;
      case (r_state)
        CHECKER_CTRL_STATE_IDLE: begin
          if (cmd_start) begin
            mode_mode <= cmd_mode;
            mode_addr <= cmd_addr;
            r_timeout <= cmd_timeout;
            status    <= '0;
            irq_count <= '0;
            res_data  <= '0;
            r_start_q <= 1'b1;
            busy      <= 1'b1;
            r_state   <= CHECKER_CTRL_STATE_START;
          end
        end
        CHECKER_CTRL_STATE_START: begin
          r_state <= CHECKER_CTRL_STATE_RUN;
        end
        CHECKER_CTRL_STATE_RUN: begin
          if (w_run_exit) begin
            res_data  <= w_sel_data;
            r_start_q <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            r_state   <= CHECKER_CTRL_STATE_DONE;
            if (!w_sel_end) begin
              if (w_sel_error) begin
                status[CHECKER_CTRL_STATUS_ERROR] <= 1'b1;
              end else if (cmd_abort) begin
                status[CHECKER_CTRL_STATUS_ABORTED] <= 1'b1;
              end else begin
                status[CHECKER_CTRL_STATUS_TIMEOUT] <= 1'b1;
              end
            end
          end else if (w_sel_irq && !mode_ack) begin
            // the engine still shows its old irq during the ack cycle
            irq       <= 1'b1;
            irq_count <= sat_inc16(irq_count);
            r_state   <= CHECKER_CTRL_STATE_IRQ;
          end
        end
        CHECKER_CTRL_STATE_IRQ: begin
          if (cmd_abort) begin
            status[CHECKER_CTRL_STATUS_ABORTED] <= 1'b1;
            irq       <= 1'b0;
            res_data  <= w_sel_data;
            r_start_q <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            r_state   <= CHECKER_CTRL_STATE_DONE;
          end else if (cmd_ack) begin
            mode_ack <= 1'b1;
            irq      <= 1'b0;
            r_state  <= CHECKER_CTRL_STATE_RUN;
          end
        end
        CHECKER_CTRL_STATE_DONE: begin
          r_state <= CHECKER_CTRL_STATE_IDLE;
        end
        default: begin
          r_state <= CHECKER_CTRL_STATE_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_checker_ctrl.sv
// tb/tb_checker_ctrl.sv - self-checking bench for checker_ctrl with dummy counting engines
module tb_checker_ctrl;

  localparam int MODE_W = 2;
  localparam int NM     = 4;
  localparam int WDT_W  = 32;

  logic              sys_clk     = 1'b0;
  logic              sys_rst     = 1'b0;
  logic              cmd_start   = 1'b0;
  logic [MODE_W-1:0] cmd_mode    = '0;
  logic [63:0]       cmd_addr    = '0;
  logic [WDT_W-1:0]  cmd_timeout = '0;
  logic              cmd_abort   = 1'b0;
  logic              cmd_ack     = 1'b0;

  logic [MODE_W-1:0] mode_mode;
  logic              mode_start;
  logic [63:0]       mode_addr;
  logic              mode_ack;
  logic [NM-1:0]     eng_end;
  logic [64*NM-1:0]  eng_data;
  logic [NM-1:0]     eng_irq;
  logic [NM-1:0]     eng_error;
  logic              busy;
  logic              done;
  logic [2:0]        status;
  logic [63:0]       res_data;
  logic              irq;
  logic [15:0]       irq_count;

  checker_ctrl #(.MODE_W(MODE_W), .WDT_W(WDT_W)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cmd_start(cmd_start), .cmd_mode(cmd_mode), .cmd_addr(cmd_addr),
    .cmd_timeout(cmd_timeout), .cmd_abort(cmd_abort), .cmd_ack(cmd_ack),
    .mode_mode(mode_mode), .mode_start(mode_start), .mode_addr(mode_addr), .mode_ack(mode_ack),
    .eng_end(eng_end), .eng_data(eng_data), .eng_irq(eng_irq), .eng_error(eng_error),
    .busy(busy), .done(done), .status(status), .res_data(res_data),
    .irq(irq), .irq_count(irq_count)
  );

  always #5 sys_clk = ~sys_clk;

  // dummy engines: count from 0 while started, end at count==addr, optional irq/error at a count
  int          cur_eng       = 0;
  int          irq_at [NM]   = '{default: 0};
  int          err_at [NM]   = '{default: 0};
  logic [63:0] e_cnt  [NM]   = '{default: 64'd0};
  logic        e_run  [NM]   = '{default: 1'b0};
  logic        e_end  [NM]   = '{default: 1'b0};
  logic        e_irq  [NM]   = '{default: 1'b0};
  logic        e_err  [NM]   = '{default: 1'b0};
  logic        e_pend [NM]   = '{default: 1'b0};
  logic [63:0] n_data        = '0;
  logic [2:0]  n_bits        = '0;

  always @(posedge sys_clk) begin
    for (int k = 0; k < NM; k++) begin
      if (mode_start && int'(mode_mode) == k) begin
        if (!e_run[k]) begin
          e_run[k] <= 1'b1; e_cnt[k] <= '0; e_end[k] <= 1'b0;
          e_irq[k] <= 1'b0; e_err[k] <= 1'b0; e_pend[k] <= 1'b0;
        end else begin
          if (mode_ack) begin e_irq[k] <= 1'b0; e_pend[k] <= 1'b0; end
          if (!e_pend[k] && !e_end[k]) begin
            e_cnt[k] <= e_cnt[k] + 64'd1;
            if (e_cnt[k] + 64'd1 == mode_addr) e_end[k] <= 1'b1;
            if (irq_at[k] != 0 && e_cnt[k] + 64'd1 == 64'(irq_at[k])) begin
              e_irq[k] <= 1'b1; e_pend[k] <= 1'b1;
            end
            if (err_at[k] != 0 && e_cnt[k] + 64'd1 == 64'(err_at[k])) e_err[k] <= 1'b1;
          end
        end
      end else begin
        e_run[k] <= 1'b0; e_irq[k] <= 1'b0; e_err[k] <= 1'b0; e_pend[k] <= 1'b0;
      end
    end
    n_data <= {$urandom, $urandom};
    n_bits <= 3'($urandom);
  end

  // the engine owning the current run shows its model, every other engine shows noise
  always_comb begin
    eng_end = '0; eng_irq = '0; eng_error = '0; eng_data = '0;
    for (int k = 0; k < NM; k++) begin
      if (k == cur_eng) begin
        eng_end[k] = e_end[k]; eng_irq[k] = e_irq[k]; eng_error[k] = e_err[k];
        eng_data[64*k +: 64] = e_cnt[k];
      end else begin
        eng_end[k] = n_bits[0]; eng_irq[k] = n_bits[1]; eng_error[k] = n_bits[2];
        eng_data[64*k +: 64] = n_data ^ 64'(k);
      end
    end
  end

  // running event counters; runs compare before/after snapshots
  int   mon_done = 0, mon_ack = 0, mon_ms = 0, mon_rise = 0;
  logic prev_ms  = 1'b0;
  always @(negedge sys_clk) begin
    if (done) mon_done++;
    if (mode_ack) mon_ack++;
    if (mode_start) mon_ms++;
    if (mode_start && !prev_ms) mon_rise++;
    prev_ms = mode_start;
  end

  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  int s_done, s_ack, s_ms, s_rise;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge sys_clk);
    #1;
    cyc++;
  endtask

  task automatic launch(input int md, input int ad, input int to);
    cur_eng     = md;
    cmd_mode    = MODE_W'(md);
    cmd_addr    = 64'(ad);
    cmd_timeout = WDT_W'(to);
    cmd_start   = 1'b1;
    s_done = mon_done; s_ack = mon_ack; s_ms = mon_ms; s_rise = mon_rise;
    step();
    cmd_start = 1'b0;
    cyc = 1;
    chk("launch_busy", 64'(busy), 64'(1));
    chk("launch_mode_start", 64'(mode_start), 64'(1));
  endtask

  task automatic wait_done(input int limit);
    while (!done && cyc < limit) step();
  endtask

  task automatic post_run(input int exp_ack);
    step();
    chk("done_single_cycle", 64'(done), 64'(0));
    chk("done_pulse_count", 64'(mon_done - s_done), 64'(1));
    chk("mode_start_launches", 64'(mon_rise - s_rise), 64'(1));
    chk("mode_ack_pulses", 64'(mon_ack - s_ack), 64'(exp_ack));
  endtask

  // irq-free run: the outcome is whichever of end / error / watchdog comes first, in that priority
  task automatic run_plain(input int md, input int ad, input int to, input int ea);
    int n, st, ms_exp;
    irq_at[md] = 0;
    err_at[md] = ea;
    n = ad + 1; st = 0;
    if (ea != 0 && ea + 1 < n) begin n = ea + 1; st = 1; end
    if (to != 0 && to < n) begin n = to; st = 4; end
    ms_exp = (st == 0) ? n : n + 1;
    launch(md, ad, to);
    wait_done(n + 40);
    chk("done_cycle", 64'(cyc), 64'(n + 2));
    chk("status", 64'(status), 64'(st));
    chk("res_data", res_data, 64'(n - 1));
    chk("done_mode_start_low", 64'(mode_start), 64'(0));
    chk("done_busy_low", 64'(busy), 64'(0));
    chk("irq_count_zero", 64'(irq_count), 64'(0));
    post_run(0);
    chk("mode_start_cycles", 64'(mon_ms - s_ms), 64'(ms_exp));
  endtask

  initial begin
    repeat (3) step();
    chk("rst_ctrl_outs", 64'({mode_mode, mode_start, mode_ack, busy, done, status, irq}), 64'(0));
    chk("rst_mode_addr", mode_addr, 64'(0));
    chk("rst_res_data", res_data, 64'(0));
    chk("rst_irq_count", 64'(irq_count), 64'(0));
    sys_rst = 1'b1;
    repeat (2) step();

    run_plain(2, 5, 0, 0);
    run_plain(1, 1000, 10, 0);
    run_plain(0, 9, 10, 0);
    run_plain(3, 20, 0, 6);

    // engine irq at count 3, host ack four cycles after irq is raised
    irq_at[1] = 3; err_at[1] = 0;
    launch(1, 8, 0);
    while (!irq && cyc < 60) step();
    chk("irq_raise_cycle", 64'(cyc), 64'(6));
    chk("irq_count_one", 64'(irq_count), 64'(1));
    chk("irq_mode_start_held", 64'(mode_start), 64'(1));
    repeat (4) step();
    cmd_ack = 1'b1;
    step();
    cmd_ack = 1'b0;
    chk("ack_mode_ack", 64'(mode_ack), 64'(1));
    chk("ack_irq_clear", 64'(irq), 64'(0));
    step();
    chk("ack_one_cycle", 64'(mode_ack), 64'(0));
    wait_done(80);
    chk("irq_done_cycle", 64'(cyc), 64'(18));
    chk("irq_run_status", 64'(status), 64'(0));
    chk("irq_run_res", res_data, 64'(8));
    chk("irq_run_count", 64'(irq_count), 64'(1));
    post_run(1);

    // host abort while an irq is pending
    irq_at[2] = 2; err_at[2] = 0;
    launch(2, 20, 0);
    while (!irq && cyc < 60) step();
    repeat (2) step();
    cmd_abort = 1'b1;
    step();
    cmd_abort = 1'b0;
    chk("abort_irq_done", 64'(done), 64'(1));
    chk("abort_irq_status", 64'(status), 64'(3'b010));
    chk("abort_irq_irq", 64'(irq), 64'(0));
    chk("abort_irq_res", res_data, 64'(2));
    chk("abort_irq_ms", 64'(mode_start), 64'(0));
    post_run(0);

    // end and abort together, plus a start attempt while busy
    irq_at[3] = 0; err_at[3] = 0;
    launch(3, 4, 0);
    step(); step();
    cmd_start = 1'b1; cmd_mode = 2'd0; cmd_addr = 64'd99;
    step();
    cmd_start = 1'b0;
    chk("busy_start_mode", 64'(mode_mode), 64'(3));
    chk("busy_start_addr", mode_addr, 64'(4));
    step(); step();
    chk("end_gates_start", 64'(mode_start), 64'(0));
    cmd_abort = 1'b1;
    step();
    cmd_abort = 1'b0;
    chk("end_abort_done", 64'(done), 64'(1));
    chk("end_abort_status", 64'(status), 64'(0));
    chk("end_abort_res", res_data, 64'(4));
    post_run(0);
    step(); step();
    chk("no_late_launch", 64'(busy), 64'(0));

    for (int i = 0; i < 12; i++) begin
      int md, ad, to, ea;
      md = int'($urandom_range(0, 3));
      ad = int'($urandom_range(1, 40));
      to = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 45));
      ea = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 40)) : 0;
      run_plain(md, ad, to, ea);
      step();
    end

    // reset in the middle of a run
    irq_at[3] = 0; err_at[3] = 0;
    launch(3, 50, 0);
    repeat (5) step();
    sys_rst = 1'b0;
    #1;
    chk("midrst_ctrl_outs", 64'({mode_mode, mode_start, mode_ack, busy, done, status, irq}), 64'(0));
    chk("midrst_mode_addr", mode_addr, 64'(0));
    chk("midrst_irq_count", 64'(irq_count), 64'(0));
    repeat (2) step();
    sys_rst = 1'b1;
    step();
    run_plain(0, 2, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
